// File: rtl/piezo_note_sequencer_pkg.sv
// Shared melody codes and sequencer state encodings for the vending FSM,
// piezo_note_sequencer and item_based_piezo.
package piezo_note_sequencer_pkg;

  typedef enum logic [3:0] {
    NOTE_NONE  = 4'd0,
    NOTE_100W  = 4'd1,
    NOTE_500W  = 4'd2,
    NOTE_1000W = 4'd3,
    NOTE_PROD1 = 4'd4,
    NOTE_PROD2 = 4'd5,
    NOTE_PROD3 = 4'd6,
    NOTE_PROD4 = 4'd7
  } note_code_e;

  localparam logic [3:0] NOTE_CODE_MAX = 4'd7;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } seq_state_e;

  // A code is playable only if it names a real melody (1..NOTE_CODE_MAX).
  function automatic logic code_valid(input logic [3:0] code);
    return (code != 4'(NOTE_NONE)) && (code <= NOTE_CODE_MAX);
  endfunction

endpackage

// File: rtl/piezo_tick_timer.sv
// Per-note duration counter: counts 0..NOTE_TICKS-1 while enabled and
// flags the last tick of each note with a one-cycle wrap pulse.
module piezo_tick_timer #(
  parameter int NOTE_TICKS = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int TW = $clog2(NOTE_TICKS);
  localparam logic [TW-1:0] LAST_TICK = TW'(NOTE_TICKS - 1);

  logic [TW-1:0] tick;

  assign wrap = en && (tick == LAST_TICK);

  // Tick counter: clear restarts a note, otherwise advance and wrap on the last tick.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    if (rst || clr) begin
      tick <= '0;
    end else if (en) begin
      tick <= wrap ? '0 : tick + 1'b1;
    end
  end

endmodule

// File: rtl/piezo_note_sequencer.sv
// Melody sequencer: on an accepted request, plays note indices 1..NUM_NOTES,
// each NOTE_TICKS cycles long, then returns silent and pulses done.
module piezo_note_sequencer
  import piezo_note_sequencer_pkg::*;
#(
  parameter int NOTE_TICKS = 250000,
  parameter int NUM_NOTES  = 4,
  parameter bit PREEMPT    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_code,
  output logic       req_ready,
  output logic [3:0] note_state,
  output logic [2:0] note_played,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_NOTE = 3'(NUM_NOTES);

  seq_state_e state;
  logic       accept;
  logic       play_en;
  logic       note_wrap;

  // Idle always takes a request; during playback only if preemption is enabled.
  assign req_ready = (state == IDLE) || PREEMPT;
  assign accept    = req_valid && req_ready && code_valid(req_code);
  assign play_en   = (state == PLAY);

  piezo_tick_timer #(
    .NOTE_TICKS(NOTE_TICKS)
  ) u_tick_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (play_en),
    .wrap (note_wrap)
  );

  // FSM with registered outputs: accept (re)starts at note 1, the last tick
  // of the last note returns to idle with a one-cycle done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      note_state  <= 4'(NOTE_NONE);
      note_played <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state       <= PLAY;
        note_state  <= req_code;
        note_played <= 3'd1;
        busy        <= 1'b1;
      end else if (state == PLAY && note_wrap) begin
        if (note_played == LAST_NOTE) begin
          state       <= IDLE;
          note_state  <= 4'(NOTE_NONE);
          note_played <= 3'd0;
          busy        <= 1'b0;
          done        <= 1'b1;
        end else begin
          note_played <= note_played + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piezo_note_sequencer.sv
// Directed bench for piezo_note_sequencer with NOTE_TICKS=4, NUM_NOTES=4.
// dut0 has PREEMPT=0, dut1 has PREEMPT=1; both share clock and reset.
module tb_piezo_note_sequencer;

  localparam int TICKS = 4;
  localparam int NOTES = 4;
  localparam int MEL   = TICKS * NOTES;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v0, v1;
  logic [3:0] c0, c1;
  logic       rdy0, rdy1, busy0, busy1, done0, done1;
  logic [3:0] st0, st1;
  logic [2:0] pl0, pl1;

  piezo_note_sequencer #(.NOTE_TICKS(TICKS), .NUM_NOTES(NOTES), .PREEMPT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_code(c0), .req_ready(rdy0),
    .note_state(st0), .note_played(pl0), .busy(busy0), .done(done0)
  );

  piezo_note_sequencer #(.NOTE_TICKS(TICKS), .NUM_NOTES(NOTES), .PREEMPT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_code(c1), .req_ready(rdy1),
    .note_state(st1), .note_played(pl1), .busy(busy1), .done(done1)
  );

  // Observed bundles: {busy, done, note_state, note_played, req_ready}
  wire [9:0] obs0 = {busy0, done0, st0, pl0, rdy0};
  wire [9:0] obs1 = {busy1, done1, st1, pl1, rdy1};

  localparam logic [9:0] IDLE_VEC = {1'b0, 1'b0, 4'd0, 3'd0, 1'b1};
  localparam logic [9:0] DONE_VEC = {1'b0, 1'b1, 4'd0, 3'd0, 1'b1};

  int vectors     = 0;
  int miscompares = 0;

  // Expected bundle k cycles after the accept edge (k=0: first cycle of note 1).
  function automatic logic [9:0] exp_vec(input logic [3:0] code, input int k, input logic rp);
    if (k < MEL)       return {1'b1, 1'b0, code, 3'(k / TICKS + 1), rp};
    else if (k == MEL) return DONE_VEC;
    else               return IDLE_VEC;
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b0; c0 = 4'd0; v1 = 1'b0; c1 = 4'd0;
    step(); step();
    rst = 1'b0;
    check("reset_dut0", obs0, IDLE_VEC);
    check("reset_dut1", obs1, IDLE_VEC);

    // 1: single-cycle request, full melody, one done, then idle
    v0 = 1'b1; c0 = 4'd1;
    step();
    v0 = 1'b0;
    check("t1_k0", obs0, exp_vec(4'd1, 0, 1'b0));
    for (int k = 1; k <= MEL + 1; k++) begin
      step();
      check($sformatf("t1_k%0d", k), obs0, exp_vec(4'd1, k, 1'b0));
    end

    // 2: invalid codes are dropped in idle
    v0 = 1'b1; c0 = 4'd0;
    step(); check("t2_code0", obs0, IDLE_VEC);
    c0 = 4'd9;
    step(); check("t2_code9", obs0, IDLE_VEC);
    c0 = 4'd15;
    step(); check("t2_code15", obs0, IDLE_VEC);
    v0 = 1'b0;
    step(); check("t2_after", obs0, IDLE_VEC);

    // 3: no preemption, code 6 during note 2 is ignored
    v0 = 1'b1; c0 = 4'd4;
    step();
    v0 = 1'b0;
    check("t3_k0", obs0, exp_vec(4'd4, 0, 1'b0));
    for (int k = 1; k <= MEL + 1; k++) begin
      if (k == 6) begin v0 = 1'b1; c0 = 4'd6; end
      if (k == 7) v0 = 1'b0;
      step();
      check($sformatf("t3_k%0d", k), obs0, exp_vec(4'd4, k, 1'b0));
    end

    // 4: preemption, code 7 at note 3 tick 1 restarts immediately
    v1 = 1'b1; c1 = 4'd4;
    step();
    v1 = 1'b0;
    check("t4_k0", obs1, exp_vec(4'd4, 0, 1'b1));
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("t4_k%0d", k), obs1, exp_vec(4'd4, k, 1'b1));
    end
    v1 = 1'b1; c1 = 4'd7;
    step();
    v1 = 1'b0;
    check("t4_pre_k0", obs1, exp_vec(4'd7, 0, 1'b1));
    for (int k = 1; k <= MEL + 1; k++) begin
      step();
      check($sformatf("t4_pre_k%0d", k), obs1, exp_vec(4'd7, k, 1'b1));
    end

    // 5: reset during note 2 silences with no done, then normal replay
    v0 = 1'b1; c0 = 4'd2;
    step();
    v0 = 1'b0;
    check("t5_k0", obs0, exp_vec(4'd2, 0, 1'b0));
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("t5_k%0d", k), obs0, exp_vec(4'd2, k, 1'b0));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst", obs0, IDLE_VEC);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t5_quiet%0d", k), obs0, IDLE_VEC);
    end
    v0 = 1'b1; c0 = 4'd3;
    step();
    v0 = 1'b0;
    check("t5_re_k0", obs0, exp_vec(4'd3, 0, 1'b0));
    for (int k = 1; k <= MEL + 1; k++) begin
      step();
      check($sformatf("t5_re_k%0d", k), obs0, exp_vec(4'd3, k, 1'b0));
    end

    // 6: request held through the done cycle starts the next melody with no gap
    v0 = 1'b1; c0 = 4'd5;
    step();
    check("t6_k0", obs0, exp_vec(4'd5, 0, 1'b0));
    c0 = 4'd1;
    for (int k = 1; k <= MEL; k++) begin
      step();
      check($sformatf("t6_k%0d", k), obs0, exp_vec(4'd5, k, 1'b0));
    end
    step();
    v0 = 1'b0;
    check("t6_next_k0", obs0, exp_vec(4'd1, 0, 1'b0));
    for (int k = 1; k <= MEL + 1; k++) begin
      step();
      check($sformatf("t6_next_k%0d", k), obs0, exp_vec(4'd1, k, 1'b0));
    end
    check("t6_dut1_idle", obs1, IDLE_VEC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
